// File: rtl/pc_sequencer.sv
// Program counter and hardware return stack for the single-cycle core.
// Selects the next PC from decode-ROM control bits and owns the run/halt state.
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jmp,
  input  logic            brh,
  input  logic            cstack_exe,
  input  logic            cstack_type,
  input  logic            pc_in_sel,
  input  logic            clk_hlt,
  input  logic [PC_W-1:0] addr,
  input  logic [1:0]      cond,
  input  logic            flag_z,
  input  logic            flag_c,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            stack_ovf,
  output logic            stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic            r_ovf;
  logic            r_unf;

  logic [PC_W-1:0]  w_pc_inc;
  logic             w_call;
  logic             w_ret;
  logic             w_taken;
  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_top_idx;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_call     = cstack_exe & ~cstack_type;
  assign w_ret      = cstack_exe &  cstack_type;
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_taken = 1'b0;
    case (cond)
      2'd0: w_taken = brh &  flag_z;
      2'd1: w_taken = brh & ~flag_z;
      2'd2: w_taken = brh &  flag_c;
      2'd3: w_taken = brh & ~flag_c;
      default: w_taken = 1'b0;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the stack is flop-based, so it is
  // reset like any other register rather than left as uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (r_state == S_RUN && !stall) begin
      if (clk_hlt) begin
        r_state <= S_HALT;
      end else if (w_ret && pc_in_sel) begin
        if (!w_empty) begin
          r_pc <= r_stack[w_top_idx];
          r_sp <= r_sp - SP_W'(1);
        end else begin
          r_pc  <= w_pc_inc;
          r_unf <= 1'b1;
        end
      end else if (w_call) begin
        if (!w_full) begin
          r_stack[w_push_idx] <= w_pc_inc;
          r_sp                <= r_sp + SP_W'(1);
        end else begin
          r_ovf <= 1'b1;
        end
        r_pc <= addr;
      end else if (jmp || w_taken) begin
        r_pc <= addr;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign pc        = r_pc;
  assign halted    = (r_state == S_HALT);
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule
